// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory loader.
// Packs one field bundle per handshake into a 32-bit word and appends an ECALL on finish.
module instr_encoder_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    typedef enum logic [1:0] {IDLE, RUN, TERM, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       ECALL = 32'h0000_0073;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr;
    logic [31:0]       enc;
    logic              legal;
    logic              accept;

    assign in_ready = (state_q == RUN) && (wptr < LAST);
    assign accept   = in_valid && in_ready;
    assign done     = (state_q == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (finish) state_d = TERM;
            TERM:                state_d = DONE;
            DONE:    if (start)  state_d = RUN;
        endcase
    end

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (op_class)
            4'd0:  enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            4'd1: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    enc = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
                else
                    enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            end
            4'd2:  enc = {imm[31:12], rd, 7'b0110111};
            4'd3:  enc = {imm[31:12], rd, 7'b0010111};
            4'd4:  enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            4'd5:  enc = {imm[11:0], rs1, funct3, rd, 7'b1100111};
            4'd6:  enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            4'd7:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            4'd8:  enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            4'd9:  enc = imm[0] ? 32'h0010_0073 : ECALL;
            4'd10: enc = {imm[11:0], 5'd0, 3'd0, 5'd0, 7'b0001111};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            count        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        wptr         <= '0;
                        count        <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (legal) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wptr;
                            mem_wdata <= enc;
                            wptr      <= wptr + 1'b1;
                            count     <= count + 1'b1;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end else if (in_valid) begin
                        // Only reachable when full: the bundle stays unconsumed.
                        err_overflow <= 1'b1;
                    end
                end
                TERM: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wptr;
                    mem_wdata <= ECALL;
                    count     <= {1'b0, wptr} + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a DEPTH=64 instance for encodings and
// sequencing, and a DEPTH=4 instance on the same stimulus for the full condition.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, finish, in_valid;
    logic [3:0]  op_class;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        a_ready, a_we, a_done, a_eill, a_eovf;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic [6:0]  a_count;

    logic        b_ready, b_we, b_done, b_eill, b_eovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(64), .ADDR_W(6)) dut_a (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(a_ready), .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .count(a_count), .done(a_done), .err_illegal(a_eill),
        .err_overflow(a_eovf)
    );

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(b_ready), .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .count(b_count), .done(b_done), .err_illegal(b_eill),
        .err_overflow(b_eovf)
    );

    // Encoding table: class, rd, rs1, rs2, funct3, funct7, imm, hand-computed word.
    logic [3:0]  t_cls [7] = '{4'd1, 4'd7, 4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
    logic [4:0]  t_rd  [7] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd5, 5'd3, 5'd3};
    logic [4:0]  t_rs1 [7] = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [4:0]  t_rs2 [7] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2};
    logic [2:0]  t_f3  [7] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0};
    logic [6:0]  t_f7  [7] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
    logic [31:0] t_imm [7] = '{32'd5, 32'd8, 32'hFFFF_FFF8, 32'd16, 32'h1234_5000,
                               32'h0000_0FFF, 32'd0};
    logic [31:0] t_exp [7] = '{32'h0050_0093, 32'h0020_A423, 32'hFE20_8CE3, 32'h0100_00EF,
                               32'h1234_52B7, 32'h41F0_D193, 32'h0020_81B3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [3:0] c, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im);
        op_class = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic expect_write(input string tag, input logic [5:0] addr, input logic [31:0] data);
        check({tag, "_we"},   {31'd0, a_we}, 32'd1);
        check({tag, "_addr"}, {26'd0, a_addr}, {26'd0, addr});
        check({tag, "_data"}, a_wdata, data);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_bundle(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #1;
        check("rst_ready", {31'd0, a_ready}, 32'd0);
        check("rst_we",    {31'd0, a_we},    32'd0);
        check("rst_count", {25'd0, a_count}, 32'd0);
        check("rst_done",  {31'd0, a_done},  32'd0);
        rst = 1'b1;
        tick();

        // finish in IDLE is ignored
        finish = 1'b1; tick(); finish = 1'b0;
        tick();
        check("idle_fin_we",   {31'd0, a_we},    32'd0);
        check("idle_fin_done", {31'd0, a_done},  32'd0);
        check("idle_fin_rdy",  {31'd0, a_ready}, 32'd0);

        // encodings, back-to-back
        start = 1'b1; tick(); start = 1'b0;
        check("start_ready", {31'd0, a_ready}, 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_bundle(t_cls[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], t_f7[i], t_imm[i]);
            tick();
            expect_write($sformatf("enc%0d", i), 6'(i), t_exp[i]);
            check($sformatf("enc%0d_count", i), {25'd0, a_count}, 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("enc_idle_we", {31'd0, a_we}, 32'd0);

        // asynchronous reset mid-load, between edges
        #2 rst = 1'b0;
        #1;
        check("arst_ready", {31'd0, a_ready}, 32'd0);
        check("arst_count", {25'd0, a_count}, 32'd0);
        check("arst_addr",  {26'd0, a_addr},  32'd0);
        check("arst_data",  a_wdata,          32'd0);
        rst = 1'b1;
        tick();
        check("arst_idle", {31'd0, a_ready}, 32'd0);

        // termination with finish on the second accept
        start = 1'b1; tick(); start = 1'b0;
        set_bundle(t_cls[0], t_rd[0], t_rs1[0], t_rs2[0], t_f3[0], t_f7[0], t_imm[0]);
        in_valid = 1'b1; tick();
        expect_write("term_w0", 6'd0, t_exp[0]);
        set_bundle(t_cls[1], t_rd[1], t_rs1[1], t_rs2[1], t_f3[1], t_f7[1], t_imm[1]);
        finish = 1'b1; tick(); finish = 1'b0; in_valid = 1'b0;
        expect_write("term_w1", 6'd1, t_exp[1]);
        check("term_notdone", {31'd0, a_done}, 32'd0);
        tick();
        expect_write("term_ecall", 6'd2, 32'h0000_0073);
        check("term_count", {25'd0, a_count}, 32'd3);
        check("term_done",  {31'd0, a_done},  32'd1);
        tick();
        check("term_we_off",  {31'd0, a_we},   32'd0);
        check("term_done_hd", {31'd0, a_done}, 32'd1);

        // illegal class, ignored start in RUN, SYSTEM/FENCE
        start = 1'b1; tick(); start = 1'b0;
        check("rs_done", {31'd0, a_done}, 32'd0);
        set_bundle(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1; tick();
        check("ill_we",    {31'd0, a_we},    32'd0);
        check("ill_flag",  {31'd0, a_eill},  32'd1);
        check("ill_count", {25'd0, a_count}, 32'd0);
        set_bundle(t_cls[0], t_rd[0], t_rs1[0], t_rs2[0], t_f3[0], t_f7[0], t_imm[0]);
        tick();
        expect_write("ill_next", 6'd0, t_exp[0]);
        in_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
        check("run_start_flag",  {31'd0, a_eill},  32'd1);
        check("run_start_count", {25'd0, a_count}, 32'd1);
        set_bundle(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1; tick();
        expect_write("ebreak", 6'd1, 32'h0010_0073);
        set_bundle(4'd10, 5'd3, 5'd4, 5'd0, 3'd7, 7'd0, 32'h0000_00FF);
        tick();
        expect_write("fence", 6'd2, 32'h0FF0_000F);
        in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
        tick();
        expect_write("ill_ecall", 6'd3, 32'h0000_0073);
        check("ill_ecount", {25'd0, a_count}, 32'd4);
        start = 1'b1; tick(); start = 1'b0;
        check("ill_cleared", {31'd0, a_eill}, 32'd0);

        // full condition on the DEPTH=4 instance
        set_bundle(t_cls[0], t_rd[0], t_rs1[0], t_rs2[0], t_f3[0], t_f7[0], t_imm[0]);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 3) begin
                check($sformatf("full%0d_we", i),   {31'd0, b_we},   32'd1);
                check($sformatf("full%0d_addr", i), {30'd0, b_addr}, 32'(i));
                check($sformatf("full%0d_ovf", i),  {31'd0, b_eovf}, 32'd0);
            end else begin
                check($sformatf("full%0d_we", i),  {31'd0, b_we},   32'd0);
                check($sformatf("full%0d_ovf", i), {31'd0, b_eovf}, 32'd1);
            end
            if (i >= 2) check($sformatf("full%0d_rdy", i), {31'd0, b_ready}, 32'd0);
        end
        in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
        check("full_term_we", {31'd0, b_we}, 32'd0);
        tick();
        check("full_ecall_we",   {31'd0, b_we},    32'd1);
        check("full_ecall_addr", {30'd0, b_addr},  32'd3);
        check("full_ecall_data", b_wdata,          32'h0000_0073);
        check("full_count",      {29'd0, b_count}, 32'd4);
        check("full_done",       {31'd0, b_done},  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
